// File: rtl/neuron_stream_driver_pkg.sv
// Shared definitions for the neuron stream driver: state encoding, pair width
// and default multiplier latency of the attached datapath.
package neuron_stream_driver_pkg;

   localparam int PAIR_W       = 8;
   localparam int DEF_MULT_LAT = 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_FEED    = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_CAPTURE = 3'd4
   } state_e;

endpackage

// File: rtl/neuron_stream_driver_if.sv
// Host-side bus of the neuron stream driver: buffer writes, launch and result.
interface neuron_stream_driver_if #(
   parameter int M      = 18,
   parameter int ADDR_W = 4
);
   import neuron_stream_driver_pkg::*;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [PAIR_W-1:0] wr_in;
   logic [PAIR_W-1:0] wr_weight;
   logic [ADDR_W:0]   n_len;
   logic              start;
   logic              busy;
   logic              done;
   logic [M-1:0]      result;

   modport master (
      output wr_en, wr_addr, wr_in, wr_weight, n_len, start,
      input  busy, done, result
   );

   modport slave (
      input  wr_en, wr_addr, wr_in, wr_weight, n_len, start,
      output busy, done, result
   );

endinterface

// File: rtl/neuron_stream_driver_pair_buffer.sv
// DEPTH x {input, weight} store: synchronous write, combinational read.
module neuron_stream_driver_pair_buffer
   import neuron_stream_driver_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic                clk,
   input  logic                we_i,
   input  logic [ADDR_W-1:0]   waddr_i,
   input  logic [2*PAIR_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0]   raddr_i,
   output logic [2*PAIR_W-1:0] rdata_o
);

   logic [2*PAIR_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/neuron_stream_driver.sv
// Streams buffered {input, weight} pairs into one neuron datapath and captures
// its activation output once the accumulator enables have drained.
//
// state   | meaning
// IDLE    | waiting for start; buffer writable
// CLEAR   | one cycle of synchronous datapath clear
// FEED    | one pair per cycle into the datapath input register
// DRAIN   | 1+MULT_LAT cycles while the enable delay line empties
// CAPTURE | sample datapath output into result; done follows
module neuron_stream_driver
   import neuron_stream_driver_pkg::*;
#(
   parameter int M        = 18,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int MULT_LAT = DEF_MULT_LAT
) (
   input  logic                 clk,
   input  logic                 rst,
   neuron_stream_driver_if.slave host,
   output logic [PAIR_W-1:0]    nd_in,
   output logic [PAIR_W-1:0]    nd_weight,
   output logic                 nd_input_register,
   output logic                 nd_acumulator_register_en,
   output logic                 nd_clear,
   input  logic [M-1:0]         nd_out
);

   localparam int EN_W  = MULT_LAT + 1;
   localparam int DRN_W = (MULT_LAT < 1) ? 1 : $clog2(MULT_LAT + 1);
   localparam logic [ADDR_W:0]  DEPTH_L    = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]  ONE_L      = (ADDR_W + 1)'(1);
   localparam logic [DRN_W-1:0] DRAIN_INIT = DRN_W'(MULT_LAT);

   state_e              state_q, state_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [ADDR_W:0]     ptr_q, ptr_d;
   logic [EN_W-1:0]     en_pipe_q, en_pipe_d;
   logic [DRN_W-1:0]    drain_q, drain_d;
   logic                done_q, done_d;
   logic [M-1:0]        result_q, result_d;
   logic                feed;
   logic                clear;
   logic                start_ok;
   logic                wr_ok;
   logic [2*PAIR_W-1:0] rd_pair;

   // done_q marks the cycle right after CAPTURE, which must still refuse start
   assign start_ok = host.start && (state_q == ST_IDLE) && !done_q;
   assign wr_ok    = host.wr_en && (state_q == ST_IDLE);

   neuron_stream_driver_pair_buffer #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_pair_buffer (
      .clk     (clk),
      .we_i    (wr_ok),
      .waddr_i (host.wr_addr),
      .wdata_i ({host.wr_in, host.wr_weight}),
      .raddr_i (ptr_q[ADDR_W-1:0]),
      .rdata_o (rd_pair)
   );

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      ptr_d    = ptr_q;
      drain_d  = drain_q;
      done_d   = 1'b0;
      result_d = result_q;
      feed     = 1'b0;
      clear    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               len_d   = (host.n_len > DEPTH_L) ? DEPTH_L : host.n_len;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            clear   = 1'b1;
            ptr_d   = '0;
            drain_d = DRAIN_INIT;
            state_d = (len_q == '0) ? ST_DRAIN : ST_FEED;
         end
         ST_FEED: begin
            feed = 1'b1;
            if (ptr_q == len_q - ONE_L) begin
               state_d = ST_DRAIN;
            end else begin
               ptr_d = ptr_q + ONE_L;
            end
         end
         ST_DRAIN: begin
            if (drain_q == '0) begin
               state_d = ST_CAPTURE;
            end else begin
               drain_d = drain_q - DRN_W'(1);
            end
         end
         ST_CAPTURE: begin
            result_d = nd_out;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      en_pipe_d = (en_pipe_q << 1) | EN_W'(feed);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         ptr_q     <= '0;
         en_pipe_q <= '0;
         drain_q   <= '0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         ptr_q     <= ptr_d;
         en_pipe_q <= en_pipe_d;
         drain_q   <= drain_d;
         done_q    <= done_d;
         result_q  <= result_d;
      end
   end

   assign host.busy   = (state_q != ST_IDLE);
   assign host.done   = done_q;
   assign host.result = result_q;

   assign nd_in                     = feed ? rd_pair[2*PAIR_W-1:PAIR_W] : '0;
   assign nd_weight                 = feed ? rd_pair[PAIR_W-1:0] : '0;
   assign nd_input_register         = feed;
   assign nd_acumulator_register_en = en_pipe_q[EN_W-1];
   assign nd_clear                  = clear;

endmodule

// File: tb/tb_neuron_stream_driver.sv
// Randomised bench for neuron_stream_driver driving a behavioural neuron datapath
// (input register, MULT_LAT multiplier stage, accumulator, identity activation).
module tb_neuron_stream_driver;
   import neuron_stream_driver_pkg::*;

   localparam int M      = 18;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam int ML     = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   neuron_stream_driver_if #(.M(M), .ADDR_W(ADDR_W)) host_if ();

   logic [7:0]   nd_in, nd_weight;
   logic         nd_input_register, nd_acc_en, nd_clear;
   logic [M-1:0] nd_out;

   neuron_stream_driver #(
      .M        (M),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .MULT_LAT (ML)
   ) dut (
      .clk                       (clk),
      .rst                       (rst),
      .host                      (host_if.slave),
      .nd_in                     (nd_in),
      .nd_weight                 (nd_weight),
      .nd_input_register         (nd_input_register),
      .nd_acumulator_register_en (nd_acc_en),
      .nd_clear                  (nd_clear),
      .nd_out                    (nd_out)
   );

   // behavioural datapath: in_reg -> one multiplier register -> accumulator
   logic [7:0]  dp_in_q   = '0;
   logic [7:0]  dp_w_q    = '0;
   logic [15:0] dp_mult_q = '0;
   logic [31:0] dp_acc_q  = '0;

   always @(posedge clk) begin
      if (nd_clear) begin
         dp_in_q   <= '0;
         dp_w_q    <= '0;
         dp_mult_q <= '0;
         dp_acc_q  <= '0;
      end else begin
         if (nd_input_register) begin
            dp_in_q <= nd_in;
            dp_w_q  <= nd_weight;
         end
         dp_mult_q <= 16'(dp_in_q) * 16'(dp_w_q);
         if (nd_acc_en) dp_acc_q <= dp_acc_q + 32'(dp_mult_q);
      end
   end
   assign nd_out = dp_acc_q[M-1:0];

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] in_ref [DEPTH];
   logic [7:0] w_ref  [DEPTH];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [M-1:0] exp_result(input int n);
      longint acc = 0;
      int     l   = (n > DEPTH) ? DEPTH : n;
      for (int k = 0; k < l; k++) acc += longint'(in_ref[k]) * longint'(w_ref[k]);
      return M'(acc);
   endfunction

   task automatic write_pair(input int a, input int vi, input int vw);
      host_if.wr_en     = 1'b1;
      host_if.wr_addr   = ADDR_W'(a);
      host_if.wr_in     = 8'(vi);
      host_if.wr_weight = 8'(vw);
      @(negedge clk);
      host_if.wr_en = 1'b0;
      in_ref[a] = 8'(vi);
      w_ref[a]  = 8'(vw);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, " busy"},   host_if.busy, 0);
      check_eq({tag, " done"},   host_if.done, 0);
      check_eq({tag, " result"}, host_if.result, 0);
      check_eq({tag, " nd_pins"}, {nd_in, nd_weight, nd_input_register, nd_acc_en, nd_clear}, 0);
   endtask

   // mode 0: plain run; 1: writes and a second start while busy; 2: start during done
   task automatic run_eval(input int n, input int mode, input string tag);
      int done_cyc = -1, en_cnt = 0, first_en = -1, last_en = -1, clr_cnt = 0;
      int fidx = 0, first_feed = -1, pair_err = 0, zero_err = 0, extra = 0;
      int l = (n > DEPTH) ? DEPTH : n;
      logic [M-1:0] res = '0;
      logic [M-1:0] exp = exp_result(n);
      host_if.n_len = (ADDR_W + 1)'(n);
      host_if.start = 1'b1;
      @(negedge clk);
      host_if.start = 1'b0;
      for (int c = 1; c <= 80; c++) begin
         if (nd_acc_en) begin
            en_cnt++;
            if (first_en < 0) first_en = c;
            last_en = c;
         end
         if (nd_clear) clr_cnt++;
         if (nd_input_register) begin
            if (first_feed < 0) first_feed = c;
            if (fidx < DEPTH && (nd_in !== in_ref[fidx] || nd_weight !== w_ref[fidx])) pair_err++;
            fidx++;
         end else if (nd_in !== 8'd0 || nd_weight !== 8'd0) begin
            zero_err++;
         end
         if (host_if.done === 1'b1) begin
            done_cyc = c;
            res = host_if.result;
            break;
         end
         if (mode == 1 && c >= 2 && c <= 4) begin
            host_if.wr_en     = 1'b1;
            host_if.wr_addr   = ADDR_W'(c - 2);
            host_if.wr_in     = 8'($urandom);
            host_if.wr_weight = 8'($urandom);
            host_if.start     = (c == 3);
         end else begin
            host_if.wr_en = 1'b0;
            host_if.start = 1'b0;
         end
         @(negedge clk);
      end
      host_if.wr_en = 1'b0;
      if (mode == 2) begin
         host_if.start = 1'b1;
         host_if.n_len = (ADDR_W + 1)'($urandom_range(1, 20));
      end
      @(negedge clk);
      host_if.start = 1'b0;
      check_eq({tag, " done_cycle"}, done_cyc, l + 4 + ML);
      check_eq({tag, " result"}, res, exp);
      check_eq({tag, " acc_en_count"}, en_cnt, l);
      check_eq({tag, " feed_count"}, fidx, l);
      check_eq({tag, " clear_count"}, clr_cnt, 1);
      check_eq({tag, " pair_errors"}, pair_err, 0);
      check_eq({tag, " idle_nonzero"}, zero_err, 0);
      if (l > 0) begin
         check_eq({tag, " first_feed"}, first_feed, 2);
         check_eq({tag, " first_acc_en"}, first_en, 3 + ML);
         check_eq({tag, " last_acc_en"}, last_en, l + 2 + ML);
      end
      check_eq({tag, " done_single"}, host_if.done, 0);
      check_eq({tag, " busy_after"}, host_if.busy, 0);
      if (mode == 1) begin
         for (int c = 0; c < 6; c++) begin
            if (host_if.done || host_if.busy) extra++;
            @(negedge clk);
         end
         check_eq({tag, " no_second_run"}, extra, 0);
      end
   endtask

   int nw, bad;

   initial begin
      host_if.wr_en     = 1'b0;
      host_if.wr_addr   = '0;
      host_if.wr_in     = '0;
      host_if.wr_weight = '0;
      host_if.n_len     = '0;
      host_if.start     = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // directed: 1..4 x 5..8 -> 70, done at cycle 9
      for (int k = 0; k < DEPTH; k++) write_pair(k, 0, 0);
      for (int k = 0; k < 4; k++) write_pair(k, k + 1, k + 5);
      run_eval(4, 0, "dot4");
      check_eq("dot4 value70", exp_result(4), 70);
      run_eval(0, 0, "len0");

      // clamp: 20 requested, 16 streamed, 255*255 each
      for (int k = 0; k < DEPTH; k++) write_pair(k, 255, 255);
      run_eval(20, 0, "clamp");

      // writes and start while busy are dropped
      for (int k = 0; k < 8; k++) write_pair(k, $urandom_range(0, 255), $urandom_range(0, 255));
      run_eval(6, 1, "busy_wr");
      run_eval(6, 0, "old_data");

      // reset in the middle of a len=8 run
      host_if.n_len = 5'd8;
      host_if.start = 1'b1;
      @(negedge clk);
      host_if.start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("midrst");
      bad = 0;
      for (int c = 0; c < 2 + ML + 4; c++) begin
         if (nd_acc_en || host_if.done) bad++;
         @(negedge clk);
      end
      check_eq("midrst stray", bad, 0);
      write_pair(0, 3, 2);
      write_pair(1, 3, 2);
      run_eval(2, 0, "after_rst");
      check_eq("after_rst value12", exp_result(2), 12);

      for (int it = 0; it < 8; it++) begin
         nw = $urandom_range(0, 6);
         for (int j = 0; j < nw; j++)
            write_pair($urandom_range(0, DEPTH - 1), $urandom_range(0, 255), $urandom_range(0, 255));
         run_eval($urandom_range(0, 20), (it % 3 == 2) ? 2 : 0, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
